pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register that replaces the simple stall-hold stage registers. It uses a valid/ready handshake with a one-entry skid buffer, so the upstream stage sees a registered ready with no combinational path from downstream ready. It adds a flush that kills in-flight beats. Payload is a hazard-tag field plus a data word, and it is instantiated between EX/MEM/WB stages of the CPU pipeline.

Parameters:
- DATA_W, 32, width of the data payload (wb data, ALU result, etc.).
- HAZ_W, 2, width of the hazard/forwarding tag carried with each beat.
- RESET_DATA, 0, value loaded into both data registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- flush  input  1  synchronous kill of all held beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept; in_ready = !skid_valid && !flush.
- in_hazard  input  HAZ_W  hazard tag of incoming beat.
- in_data  input  DATA_W  data of incoming beat.
- out_valid  output  1  main entry holds a valid beat (registered).
- out_ready  input  1  downstream accepts.
- out_hazard  output  HAZ_W  main hazard tag; forced to 0 when out_valid=0.
- out_data  output  DATA_W  main data register (held even when invalid).
- occupancy  output  2  main_valid + skid_valid (0..2).

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid flag.
- Invariant: skid_valid=1 implies main_valid=1.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (rst=0, async): main_valid=0, skid_valid=0, hazard regs=0, data regs=RESET_DATA. While reset: out_valid=0, out_hazard=0, out_data=RESET_DATA, occupancy=0, in_ready=1 (flush low).
- Latency: an accepted beat appears on out_* the next cycle. Throughput is 1 beat/cycle when out_ready stays high.
- Transitions when flush=0:
  - main empty, accept: main<=in.
  - main full, pop, skid empty, accept: main<=in.
  - main full, pop, skid empty, no accept: main empties.
  - main full, no pop, accept: skid<=in. in_ready drops the next cycle.
  - main full, pop, skid full: main<=skid, skid empties. No accept is possible (in_ready=0).
  - main full, no pop, skid full: hold everything.
- Ordering: beats leave strictly in acceptance order. No beat is ever duplicated or dropped except by flush.
- Flush (priority over all else): the next state has both valids 0. in_ready=0 during flush, so an input beat in that cycle is not accepted. A pop in the same cycle still counts as delivered to downstream. Data registers are not cleared by flush.
- out_hazard is masked to 0 whenever out_valid=0, so the hazard unit never matches a dead beat.
- Reset asserted mid-transfer: state clears immediately (async). The first accept is possible in the first clock after release.

Test Plan:
- Reset/idle: rst=0 then release, no traffic -> out_valid=0, out_hazard=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles with hazard 1,2,3 -> outputs appear one cycle later in the same order with matching tags, occupancy=1 throughout, in_ready stays 1.
- Backpressure/skid: out_ready=0, send 0xA0 then 0xA1 -> occupancy 1 then 2, in_ready=0 after the second accept, 0xA2 held upstream. Raise out_ready -> 0xA0, 0xA1, 0xA2 emerge in order with none lost.
- Flush with full skid: occupancy=2, assert flush for 1 cycle with in_valid=1 (0xFF) -> next cycle out_valid=0, occupancy=0, out_hazard=0, 0xFF not accepted; in_ready=1 the following cycle.
- Pop+accept with full skid: occupancy=2, out_ready=1 one cycle -> main takes the skid beat, occupancy=1, in_ready=1 next cycle.
- Async reset mid-stream: pull rst low between clock edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately without a clock edge.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Upstream ready is registered (depends only on skid occupancy and flush); flush kills held beats.
module pipe_stage_skid_reg #(
  parameter int unsigned            DATA_W     = 32,
  parameter int unsigned            HAZ_W      = 2,
  parameter logic [DATA_W-1:0]      RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HAZ_W-1:0]  in_hazard,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HAZ_W-1:0]  out_hazard,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [HAZ_W-1:0]  main_hazard_q, main_hazard_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [HAZ_W-1:0]  skid_hazard_q, skid_hazard_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic pop;

  assign in_ready = !skid_valid_q && !flush;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    main_valid_d  = main_valid_q;
    main_hazard_d = main_hazard_q;
    main_data_d   = main_data_q;
    skid_valid_d  = skid_valid_q;
    skid_hazard_d = skid_hazard_q;
    skid_data_d   = skid_data_q;

    if (flush) begin
      // Payload registers keep their contents; only the valid flags are killed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d  = 1'b1;
        main_hazard_d = in_hazard;
        main_data_d   = in_data;
      end
    end else if (skid_valid_q) begin
      // in_ready is low here, so the only possible move is skid -> main.
      if (pop) begin
        main_hazard_d = skid_hazard_q;
        main_data_d   = skid_data_q;
        skid_valid_d  = 1'b0;
      end
    end else if (pop) begin
      if (accept) begin
        main_hazard_d = in_hazard;
        main_data_d   = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d  = 1'b1;
      skid_hazard_d = in_hazard;
      skid_data_d   = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q  <= 1'b0;
      main_hazard_q <= '0;
      main_data_q   <= RESET_DATA;
      skid_valid_q  <= 1'b0;
      skid_hazard_q <= '0;
      skid_data_q   <= RESET_DATA;
    end else begin
      main_valid_q  <= main_valid_d;
      main_hazard_q <= main_hazard_d;
      main_data_q   <= main_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_hazard_q <= skid_hazard_d;
      skid_data_q   <= skid_data_d;
    end
  end

  // Masking the tag keeps the hazard unit from matching a dead beat.
  assign out_valid  = main_valid_q;
  assign out_hazard = main_valid_q ? main_hazard_q : '0;
  assign out_data   = main_data_q;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: beats in flight are modelled as an ordered queue.
module tb_pipe_stage_skid_reg;

  localparam int unsigned       DATA_W = 32;
  localparam int unsigned       HAZ_W  = 2;
  localparam logic [DATA_W-1:0] RST_D  = 32'hDEAD_0001;

  typedef struct packed {
    logic [HAZ_W-1:0]  haz;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [HAZ_W-1:0]  in_hazard = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [HAZ_W-1:0]  out_hazard;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int failures = 0;

  beat_t             q[$];
  logic [DATA_W-1:0] last_head = RST_D;
  logic              acc;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .HAZ_W(HAZ_W), .RESET_DATA(RST_D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_hazard(in_hazard), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_hazard(out_hazard), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so this sees exactly what the next rising edge will.
  always @(negedge clk) begin
    int n;
    beat_t b;
    if (!rst) begin
      q.delete();
      last_head = RST_D;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_hazard", 64'(out_hazard), 64'd0);
      check("rst_out_data", 64'(out_data), 64'(RST_D));
      check("rst_in_ready", 64'(in_ready), 64'(!flush));
    end else begin
      n = q.size();
      check("occupancy", 64'(occupancy), 64'(n));
      check("out_valid", 64'(out_valid), 64'(n > 0));
      check("in_ready", 64'(in_ready), 64'((n < 2) && !flush));
      check("out_hazard", 64'(out_hazard), (n > 0) ? 64'(q[0].haz) : 64'd0);
      check("out_data", 64'(out_data), (n > 0) ? 64'(q[0].data) : 64'(last_head));
      if (n > 0) last_head = q[0].data;
      if (out_valid && out_ready) begin
        if (n == 0) begin
          check("spurious_pop", 64'd1, 64'd0);
        end else begin
          b = q.pop_front();
          check("pop_data", 64'(out_data), 64'(b.data));
          check("pop_hazard", 64'(out_hazard), 64'(b.haz));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{haz: in_hazard, data: in_data});
    end
  end

  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [HAZ_W-1:0] h, input logic [DATA_W-1:0] d);
    in_valid  = 1'b1;
    in_hazard = h;
    in_data   = d;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (occupancy != 2'd0 && k < 20) begin
      step();
      k++;
    end
    check("drain_timeout", 64'(occupancy), 64'd0);
  endtask

  initial begin
    step(); step();
    rst = 1'b1;
    step(); step();

    // Streaming at full rate
    out_ready = 1'b1;
    send(2'd1, 32'h11); step();
    send(2'd2, 32'h22); step();
    send(2'd3, 32'h33); step();
    in_valid = 1'b0; step(); step();

    // Backpressure into the skid, then release
    out_ready = 1'b0;
    send(2'd1, 32'hA0); step();
    send(2'd2, 32'hA1); step();
    send(2'd3, 32'hA2); step(); step();
    out_ready = 1'b1;
    while (!acc) step();
    drain();

    // Flush with full skid and a live input beat
    out_ready = 1'b0;
    send(2'd3, 32'hB0); step();
    send(2'd2, 32'hB1); step();
    check("pre_flush_occ", 64'(occupancy), 64'd2);
    send(2'd1, 32'hFF); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; step(); step();

    // Pop with full skid: skid beat moves to main
    send(2'd1, 32'hC0); step();
    send(2'd2, 32'hC1); step();
    send(2'd3, 32'hC2); out_ready = 1'b1; step();
    out_ready = 1'b0; in_valid = 1'b0; step();
    check("skid_to_main_occ", 64'(occupancy), 64'd1);
    drain();

    // Async reset between edges with a full stage
    out_ready = 1'b0;
    send(2'd2, 32'hD0); step();
    send(2'd1, 32'hD1); step();
    in_valid = 1'b0;
    check("pre_reset_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_occupancy", 64'(occupancy), 64'd0);
    check("async_out_hazard", 64'(out_hazard), 64'd0);
    step();
    rst = 1'b1;
    send(2'd3, 32'hE0); out_ready = 1'b1; step();
    in_valid = 1'b0; step();

    // Randomized traffic; the source holds a beat until it is taken
    acc = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_hazard = HAZ_W'($urandom);
        in_data   = $urandom;
      end
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      step();
    end
    drain();
    step();
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
